// File: rtl/unstriper_2lane.sv
// Two-lane reassembler: per-lane FIFOs absorb inter-lane skew and the output
// re-emits words strictly alternating lane0, lane1, at most one per clk_2f cycle.
module unstriper_2lane #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk_2f,
    input  logic             reset,
    input  logic [WIDTH-1:0] lane0,
    input  logic             valid0,
    input  logic [WIDTH-1:0] lane1,
    input  logic             valid1,
    output logic [WIDTH-1:0] dataOut,
    output logic             validOut,
    output logic             err,
    output logic             sel
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    typedef enum logic {
        WAIT_L0 = 1'b0,
        WAIT_L1 = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mem0 [DEPTH];
    logic [WIDTH-1:0] mem1 [DEPTH];
    logic [AW-1:0]    wp0, rp0, wp1, rp1;
    logic [AW:0]      cnt0, cnt1;
    logic             pop0, pop1, wr0, wr1;

    // Handshake: validN is a one-cycle push with no ready; a push into a full,
    // unpopped lane is dropped and latches err. validOut has no backpressure.
    assign pop0 = (state == WAIT_L0) && (cnt0 != '0);
    assign pop1 = (state == WAIT_L1) && (cnt1 != '0);
    assign wr0  = valid0 && ((cnt0 != FULL) || pop0);
    assign wr1  = valid1 && ((cnt1 != FULL) || pop1);
    assign sel  = (state == WAIT_L1);

    // Storage is not reset; pointers and counts alone define what is buffered.
    always_ff @(posedge clk_2f) begin
        if (wr0) mem0[wp0] <= lane0;
        if (wr1) mem1[wp1] <= lane1;
    end

    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            state    <= WAIT_L0;
            wp0      <= '0;
            rp0      <= '0;
            wp1      <= '0;
            rp1      <= '0;
            cnt0     <= '0;
            cnt1     <= '0;
            dataOut  <= '0;
            validOut <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (wr0)  wp0 <= wp0 + PTR_ONE;
            if (pop0) rp0 <= rp0 + PTR_ONE;
            if (wr1)  wp1 <= wp1 + PTR_ONE;
            if (pop1) rp1 <= rp1 + PTR_ONE;

            if (wr0 && !pop0)      cnt0 <= cnt0 + CNT_ONE;
            else if (pop0 && !wr0) cnt0 <= cnt0 - CNT_ONE;
            if (wr1 && !pop1)      cnt1 <= cnt1 + CNT_ONE;
            else if (pop1 && !wr1) cnt1 <= cnt1 - CNT_ONE;

            if ((valid0 && !wr0) || (valid1 && !wr1)) err <= 1'b1;

            validOut <= pop0 || pop1;
            if (pop0) begin
                dataOut <= mem0[rp0];
                state   <= WAIT_L1;
            end else if (pop1) begin
                dataOut <= mem1[rp1];
                state   <= WAIT_L0;
            end
        end
    end
endmodule

// File: tb/tb_unstriper_2lane.sv
// Bench for unstriper_2lane: cycle-exact vector table for skew/overflow, plus a
// scoreboard of expected output order for streaming, reset and pointer-wrap runs.
module tb_unstriper_2lane;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic             clk_2f = 1'b0;
    logic             reset  = 1'b0;
    logic [WIDTH-1:0] lane0  = '0;
    logic [WIDTH-1:0] lane1  = '0;
    logic             valid0 = 1'b0;
    logic             valid1 = 1'b0;
    logic [WIDTH-1:0] dataOut;
    logic             validOut;
    logic             err;
    logic             sel;

    always #5 clk_2f = ~clk_2f;

    unstriper_2lane #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_2f   (clk_2f),
        .reset    (reset),
        .lane0    (lane0),
        .valid0   (valid0),
        .lane1    (lane1),
        .valid1   (valid1),
        .dataOut  (dataOut),
        .validOut (validOut),
        .err      (err),
        .sel      (sel)
    );

    typedef struct {
        logic             v0;
        logic [WIDTH-1:0] d0;
        logic             v1;
        logic [WIDTH-1:0] d1;
        logic             ev;
        logic [WIDTH-1:0] ed;
        logic             ee;
    } vec_t;

    vec_t             tbl [25];
    int               n_vec = 0;
    int               n_bad = 0;
    logic [WIDTH-1:0] exp_q [$];
    logic [WIDTH-1:0] pend0 [$];
    logic [WIDTH-1:0] pend1 [$];
    logic [WIDTH-1:0] mon_exp;
    bit               next_lane = 1'b0;
    bit               mon_en = 1'b0;
    int               cyc = 0;
    int               n_out = 0;
    int               first_cyc = -1;
    int               last_cyc = -1;

    always @(posedge clk_2f) cyc <= cyc + 1;

    function automatic vec_t mk(input logic v0, input logic [WIDTH-1:0] d0,
                                input logic v1, input logic [WIDTH-1:0] d1,
                                input logic ev, input logic [WIDTH-1:0] ed,
                                input logic ee);
        vec_t v;
        v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1;
        v.ev = ev; v.ed = ed; v.ee = ee;
        return v;
    endfunction

    // Expected output order: lane0 word k, lane1 word k, lane0 word k+1, ...
    function automatic void merge();
        while ((next_lane == 1'b0 && pend0.size() > 0) ||
               (next_lane == 1'b1 && pend1.size() > 0)) begin
            if (next_lane == 1'b0) exp_q.push_back(pend0.pop_front());
            else                   exp_q.push_back(pend1.pop_front());
            next_lane = ~next_lane;
        end
    endfunction

    function automatic void flush_model();
        exp_q.delete();
        pend0.delete();
        pend1.delete();
        next_lane = 1'b0;
    endfunction

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v0, input logic [WIDTH-1:0] d0,
                         input logic v1, input logic [WIDTH-1:0] d1,
                         input bit track);
        @(negedge clk_2f);
        valid0 = v0;
        lane0  = d0;
        valid1 = v1;
        lane1  = d1;
        if (track) begin
            if (v0) pend0.push_back(d0);
            if (v1) pend1.push_back(d1);
            merge();
        end
    endtask

    task automatic idle_check(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, '0, 1'b0, '0, 1'b0);
            @(posedge clk_2f);
            #1;
            check({name, "_valid"}, 32'(validOut), 32'(0));
            check({name, "_data"}, dataOut, '0);
        end
    endtask

    // Scoreboard: every validOut cycle must match the head of exp_q.
    always @(negedge clk_2f) begin
        if (mon_en && reset && validOut) begin
            n_vec++;
            n_out++;
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_extra: got %h expected no output", dataOut);
            end else begin
                mon_exp = exp_q.pop_front();
                if (dataOut !== mon_exp) begin
                    n_bad++;
                    $display("FAIL sb_data: got %h expected %h", dataOut, mon_exp);
                end
            end
        end
    end

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] w;
        logic [WIDTH-1:0] r;

        // Skew (lane1 three cycles behind), then a 6-word lane0 burst overflowing.
        tbl[0]  = mk(1, 32'hFFFFFFFF, 0, 0,            0, 32'h0,        0);
        tbl[1]  = mk(1, 32'hFFFFFFFD, 0, 0,            1, 32'hFFFFFFFF, 0);
        tbl[2]  = mk(0, 0,            0, 0,            0, 32'hFFFFFFFF, 0);
        tbl[3]  = mk(0, 0,            1, 32'hFFFFFFFE, 0, 32'hFFFFFFFF, 0);
        tbl[4]  = mk(0, 0,            1, 32'hFFFFFFFC, 1, 32'hFFFFFFFE, 0);
        tbl[5]  = mk(0, 0,            0, 0,            1, 32'hFFFFFFFD, 0);
        tbl[6]  = mk(0, 0,            0, 0,            1, 32'hFFFFFFFC, 0);
        tbl[7]  = mk(0, 0,            0, 0,            0, 32'hFFFFFFFC, 0);
        tbl[8]  = mk(1, 32'hA0000000, 0, 0,            0, 32'hFFFFFFFC, 0);
        tbl[9]  = mk(1, 32'hA0000001, 0, 0,            1, 32'hA0000000, 0);
        tbl[10] = mk(1, 32'hA0000002, 0, 0,            0, 32'hA0000000, 0);
        tbl[11] = mk(1, 32'hA0000003, 0, 0,            0, 32'hA0000000, 0);
        tbl[12] = mk(1, 32'hA0000004, 0, 0,            0, 32'hA0000000, 0);
        tbl[13] = mk(1, 32'hA0000005, 0, 0,            0, 32'hA0000000, 1);
        tbl[14] = mk(0, 0,            0, 0,            0, 32'hA0000000, 1);
        tbl[15] = mk(0, 0,            1, 32'hB0000000, 0, 32'hA0000000, 1);
        tbl[16] = mk(0, 0,            1, 32'hB0000001, 1, 32'hB0000000, 1);
        tbl[17] = mk(0, 0,            1, 32'hB0000002, 1, 32'hA0000001, 1);
        tbl[18] = mk(0, 0,            1, 32'hB0000003, 1, 32'hB0000001, 1);
        tbl[19] = mk(0, 0,            0, 0,            1, 32'hA0000002, 1);
        tbl[20] = mk(0, 0,            0, 0,            1, 32'hB0000002, 1);
        tbl[21] = mk(0, 0,            0, 0,            1, 32'hA0000003, 1);
        tbl[22] = mk(0, 0,            0, 0,            1, 32'hB0000003, 1);
        tbl[23] = mk(0, 0,            0, 0,            1, 32'hA0000004, 1);
        tbl[24] = mk(0, 0,            0, 0,            0, 32'hA0000004, 1);

        // Power-on reset, then release with no traffic.
        repeat (2) @(posedge clk_2f);
        #1;
        check("rst_valid", 32'(validOut), 32'(0));
        check("rst_data", dataOut, '0);
        check("rst_err", 32'(err), 32'(0));
        @(negedge clk_2f);
        reset = 1'b1;
        idle_check(3, "post_rst");

        for (int i = 0; i < 25; i++) begin
            drive(tbl[i].v0, tbl[i].d0, tbl[i].v1, tbl[i].d1, 1'b0);
            @(posedge clk_2f);
            #1;
            check($sformatf("tbl%0d_valid", i), 32'(validOut), 32'(tbl[i].ev));
            check($sformatf("tbl%0d_data", i), dataOut, tbl[i].ed);
            check($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].ee));
        end

        // Asynchronous reset mid-cycle with traffic on both lanes.
        drive(1'b1, 32'h11, 1'b1, 32'h22, 1'b0);
        @(posedge clk_2f);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_data", dataOut, '0);
        check("async_rst_valid", 32'(validOut), 32'(0));
        check("async_rst_err", 32'(err), 32'(0));
        @(negedge clk_2f);
        valid0 = 1'b0;
        valid1 = 1'b0;
        reset  = 1'b1;
        idle_check(3, "async_rel");

        // Long in-order stream: both lanes valid every other cycle.
        flush_model();
        mon_en = 1'b1;
        n_out = 0;
        first_cyc = -1;
        for (int c = 0; c < 1600; c++) begin
            w = 32'hFFFFFFFF - 32'(c);
            if (c % 2 == 0) drive(1'b1, w, 1'b1, w - 32'd1, 1'b1);
            else            drive(1'b0, '0, 1'b0, '0, 1'b1);
        end
        repeat (4) drive(1'b0, '0, 1'b0, '0, 1'b1);
        @(posedge clk_2f);
        #1;
        check("stream_count", 32'(n_out), 32'd1600);
        check("stream_no_gap", 32'(last_cyc - first_cyc), 32'd1599);
        check("stream_drained", 32'(exp_q.size()), 32'd0);
        check("stream_err", 32'(err), 32'(0));

        // Reset mid-operation with three lane0 words buffered.
        for (int k = 0; k < 4; k++) begin
            r = 32'($urandom_range(32'h7FFFFFFF, 0));
            drive(1'b1, r, 1'b0, '0, 1'b1);
        end
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        #2;
        reset = 1'b0;
        flush_model();
        @(negedge clk_2f);
        reset = 1'b1;
        n_out = 0;
        r = 32'($urandom_range(32'h7FFFFFFF, 0));
        w = 32'($urandom_range(32'h7FFFFFFF, 0));
        drive(1'b1, r, 1'b1, w, 1'b1);
        repeat (4) drive(1'b0, '0, 1'b0, '0, 1'b1);
        @(posedge clk_2f);
        #1;
        check("midrst_count", 32'(n_out), 32'd2);
        check("midrst_drained", 32'(exp_q.size()), 32'd0);
        check("midrst_err", 32'(err), 32'(0));

        // Lane0 kept full with a pop and a push on the same edge; pointers wrap.
        for (int k = 0; k < 5; k++)
            drive(1'b1, 32'($urandom), 1'b0, '0, 1'b1);
        for (int k = 0; k < 3 * DEPTH; k++) begin
            drive(1'b0, '0, 1'b1, 32'($urandom), 1'b1);
            drive(1'b0, '0, 1'b0, '0, 1'b1);
            drive(1'b1, 32'($urandom), 1'b0, '0, 1'b1);
            @(posedge clk_2f);
            #1;
            check($sformatf("wrap%0d_err", k), 32'(err), 32'(0));
        end
        for (int k = 0; k < DEPTH; k++) begin
            drive(1'b0, '0, 1'b1, 32'($urandom), 1'b1);
            drive(1'b0, '0, 1'b0, '0, 1'b1);
            drive(1'b0, '0, 1'b0, '0, 1'b1);
        end
        repeat (3) drive(1'b0, '0, 1'b0, '0, 1'b1);
        @(posedge clk_2f);
        #1;
        check("wrap_drained", 32'(exp_q.size()), 32'd0);
        check("wrap_pending", 32'(pend0.size() + pend1.size()), 32'd0);
        check("wrap_err_final", 32'(err), 32'(0));

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/unstriper_2lane.md
# unstriper_2lane

Two-lane byte-stripe reassembler: the receive end of the striping datapath. Accepts WIDTH-bit words on two independent lanes (lane0 carries words 0, 2, 4…, lane1 carries words 1, 3, 5…), buffers each lane in a small FIFO to absorb inter-lane skew, and re-emits a single in-order stream on dataOut/validOut at up to one word per clk_2f cycle. Sits between the per-lane receive paths and the single-stream consumer; it is the counterpart of the striping block.

## Interface
- WIDTH, 32, word width of lanes and output
- DEPTH, 4, per-lane FIFO depth in words; power of two, ≥2
- clk_2f  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low; 0 clears all state immediately
- lane0  input  WIDTH  even-index words
- valid0  input  1  lane0 word present this cycle
- lane1  input  WIDTH  odd-index words
- valid1  input  1  lane1 word present this cycle
- dataOut  output  WIDTH  reassembled word, registered
- validOut  output  1  dataOut holds a new word this cycle, registered
- err  output  1  sticky lane-overflow flag, registered

## Operation
- Per lane: FIFO of DEPTH×WIDTH, write pointer, read pointer (log2(DEPTH) bits, wrap modulo DEPTH), count (log2(DEPTH)+1 bits).
- Write: validN=1 pushes laneN at the edge if countN<DEPTH, or if the same lane is popped in that cycle (full FIFO with simultaneous pop accepts).
- Overflow: validN=1 on a full FIFO not popped that cycle → word dropped, pointers unchanged, err←1; err holds until reset.
- Selector sel (1 bit, reset 0) names the lane owing the next word. States: WAIT_L0 (sel=0), WAIT_L1 (sel=1).
- Each edge: if count[sel]≠0 (registered count, before this cycle's write) → pop head, dataOut←head, validOut←1, sel←~sel. Otherwise validOut←0, dataOut holds previous value, sel holds.
- A word written at an edge is never popped at that same edge (no bypass).
- Order is strictly alternating lane0, lane1; a stalled lane stalls output while the other lane keeps buffering.
- Sustained throughput: one word/cycle total; combined input above that rate eventually overflows.

## Timing
- Reset (reset=0, async): dataOut=0, validOut=0, err=0, sel=0, all pointers and counts=0; buffered words discarded. Release is sampled at the next rising edge; first pop is always from lane0.
- Latency: word sampled on lane at edge N, available in dataOut/validOut after edge N+1 at the earliest (one-cycle latency).
- validOut is high for exactly one cycle per word; no backpressure input, consumer must accept every validOut cycle.
- Count update per edge: countN + write − pop; simultaneous write and pop leaves count unchanged, both pointers advance.
- Pointer wrap: DEPTH−1 → 0 with no gap or duplicate word.
- Both lanes valid on the same cycle: both written; only sel lane popped.

## Test plan
- Reset: drive reset=0 mid-cycle with traffic present → dataOut=0, validOut=0, err=0 asynchronously; after release with no valids, validOut stays 0 and dataOut stays 0.
- In-order stream: lane0=0xFFFFFFFF,0xFFFFFFFD,…, lane1=0xFFFFFFFE,0xFFFFFFFC,…, valid0=valid1=1 every other cycle for 1600 cycles → dataOut=0xFFFFFFFF,0xFFFFFFFE,0xFFFFFFFD,… consecutive decrementing, no gaps after fill, err=0.
- Skew: lane1 delayed 3 cycles relative to lane0 → 0xFFFFFFFF output once, validOut=0 until lane1 word 0xFFFFFFFE arrives, then order fully preserved, err=0.
- Overflow (DEPTH=4): valid0=1 for 6 consecutive cycles, valid1=0 → first word output, sel stalls on lane1; words 2–5 fill lane0 FIFO, sixth word dropped, err=1 and stays 1; subsequent lane1 words release the 4 buffered lane0 words in order.
- Wrap/simultaneous: lane0 FIFO full, pop and write on the same edge → write accepted, count stays 4, err=0; continue 3×DEPTH words to exercise pointer wrap → output sequence intact.
- Reset mid-operation: 3 words buffered, pulse reset=0 → buffered words never appear; after release, first validOut carries the next new lane0 word.
